// File: rtl/dadda_bist_engine_if.sv
// ============================================================================
// Module      : dadda_bist_engine_if
// Description : Control, operand, product and metric signals between the
//               BIST engine (master) and its user / multiplier side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dadda_bist_engine_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic [WIDTH-1:0]     out;
  logic [WIDTH-1:0]     overflow;
  logic [2*WIDTH:0]     err_count;
  logic [4*WIDTH-1:0]   err_sum;
  logic [2*WIDTH-1:0]   err_max;
  logic [WIDTH-1:0]     fail_in1;
  logic [WIDTH-1:0]     fail_in2;
  logic                 fail_valid;

  // Engine side: drives operands and results, receives start and the product
  modport master (
    input  start, out, overflow,
    output busy, done, in1, in2, err_count, err_sum, err_max,
           fail_in1, fail_in2, fail_valid
  );

  // User / multiplier side
  modport slave (
    output start, out, overflow,
    input  busy, done, in1, in2, err_count, err_sum, err_max,
           fail_in1, fail_in2, fail_valid
  );
endinterface

`default_nettype wire

// File: rtl/dadda_bist_engine.sv
// ============================================================================
// Module      : dadda_bist_engine
// Description : Exhaustive stimulus/response engine for WIDTH-bit multipliers.
//               Sweeps every operand pair (in1 outer, in2 inner), holds each
//               pair SETTLE_CYCLES cycles, then compares {overflow,out} with
//               the exact product and accumulates error metrics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dadda_bist_engine #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  dadda_bist_engine_if.master  io_bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] c_cnt_last = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DRIVE  = 2'd1;
  localparam logic [1:0] c_SAMPLE = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_in1;
  logic [WIDTH-1:0]     r_in2;
  logic [2*WIDTH:0]     r_err_count;
  logic [4*WIDTH-1:0]   r_err_sum;
  logic [2*WIDTH-1:0]   r_err_max;
  logic [WIDTH-1:0]     r_fail_in1;
  logic [WIDTH-1:0]     r_fail_in2;
  logic                 r_fail_valid;

  logic                 w_accept;
  logic                 w_last_pair;
  logic [2*WIDTH-1:0]   w_exact;
  logic [2*WIDTH-1:0]   w_dut;
  logic [2*WIDTH-1:0]   w_ed;
  logic                 w_mismatch;

  // Start is only honoured while idle or finished
  assign w_accept    = io_bus.start && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_last_pair = (&r_in1) && (&r_in2);

  // Reference product and absolute error distance of the current pair
  assign w_exact    = {{WIDTH{1'b0}}, r_in1} * {{WIDTH{1'b0}}, r_in2};
  assign w_dut      = {io_bus.overflow, io_bus.out};
  assign w_ed       = (w_exact >= w_dut) ? (w_exact - w_dut) : (w_dut - w_exact);
  assign w_mismatch = (w_ed != '0);

  // Sequencer: DRIVE for SETTLE_CYCLES cycles, then one SAMPLE cycle per pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (w_accept) begin
            r_state <= c_DRIVE;
            r_cnt   <= '0;
          end
        end
        c_DRIVE: begin
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == c_cnt_last) begin
            r_state <= c_SAMPLE;
          end
        end
        c_SAMPLE: begin
          r_cnt   <= '0;
          r_state <= w_last_pair ? c_DONE : c_DRIVE;
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Operand generator: in2 is the inner loop; the final pair stays at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in1 <= '0;
      r_in2 <= '0;
    end else if (w_accept) begin
      r_in1 <= '0;
      r_in2 <= '0;
    end else if ((r_state == c_SAMPLE) && !w_last_pair) begin
      {r_in1, r_in2} <= {r_in1, r_in2} + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Error metrics: cleared on accepted start, updated only in SAMPLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count  <= '0;
      r_err_sum    <= '0;
      r_err_max    <= '0;
      r_fail_in1   <= '0;
      r_fail_in2   <= '0;
      r_fail_valid <= 1'b0;
    end else if (w_accept) begin
      r_err_count  <= '0;
      r_err_sum    <= '0;
      r_err_max    <= '0;
      r_fail_in1   <= '0;
      r_fail_in2   <= '0;
      r_fail_valid <= 1'b0;
    end else if ((r_state == c_SAMPLE) && w_mismatch) begin
      r_err_count <= r_err_count + {{(2*WIDTH){1'b0}}, 1'b1};
      r_err_sum   <= r_err_sum + {{(2*WIDTH){1'b0}}, w_ed};
      if (w_ed > r_err_max) begin
        r_err_max <= w_ed;
      end
      if (!r_fail_valid) begin
        r_fail_in1   <= r_in1;
        r_fail_in2   <= r_in2;
        r_fail_valid <= 1'b1;
      end
    end
  end

  assign io_bus.busy       = (r_state == c_DRIVE) || (r_state == c_SAMPLE);
  assign io_bus.done       = (r_state == c_DONE);
  assign io_bus.in1        = r_in1;
  assign io_bus.in2        = r_in2;
  assign io_bus.err_count  = r_err_count;
  assign io_bus.err_sum    = r_err_sum;
  assign io_bus.err_max    = r_err_max;
  assign io_bus.fail_in1   = r_fail_in1;
  assign io_bus.fail_in2   = r_fail_in2;
  assign io_bus.fail_valid = r_fail_valid;

endmodule

`default_nettype wire

// File: doc/dadda_bist_engine.md
Name: dadda_bist_engine

Overview:
- Synthesizable stimulus and response engine for the WIDTH-bit Dadda multipliers, exact or approximate.
- Sweeps every operand pair exhaustively, drives the pairs into the DUT and samples the product as {overflow,out}.
- Compares each sample against the exact product and accumulates error metrics: error count, sum of error distance, maximum error distance, first failing pair.
- Sits on the driving/checking end of the multiplier interface and replaces the fixed-vector simulation bench for on-chip or long-run characterisation.

Parameters:
- WIDTH, 8: operand width; the product is 2*WIDTH bits, split into out (low WIDTH bits) and overflow (high WIDTH bits).
- SETTLE_CYCLES, 1: number of cycles (>=1) each operand pair is held before the result is sampled.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sweep request; sampled in IDLE and DONE only.
- busy  output  1  high in DRIVE and SAMPLE.
- done  output  1  level; high in DONE until the next accepted start or reset.
- in1  output  WIDTH  operand A to the DUT.
- in2  output  WIDTH  operand B to the DUT.
- out  input  WIDTH  DUT product, low half.
- overflow  input  WIDTH  DUT product, high half.
- err_count  output  2*WIDTH+1  number of mismatching pairs.
- err_sum  output  4*WIDTH  sum of |exact - dut| over the sweep.
- err_max  output  2*WIDTH  maximum |exact - dut|.
- fail_in1  output  WIDTH  operand A of the first mismatch; 0 if none.
- fail_in2  output  WIDTH  operand B of the first mismatch; 0 if none.
- fail_valid  output  1  high once a first mismatch has been captured.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs are 0, including in1, in2 and every metric; the settle counter is 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE, start=1:
  - Go to DRIVE.
  - in1=0, in2=0.
  - Clear all metrics and fail_*.
  - Settle counter=0; done drops.
- DRIVE:
  - Operands held stable.
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, go to SAMPLE.
  - DRIVE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - exact = in1*in2 at full 2*WIDTH width.
  - dut = {overflow,out}.
  - ed = absolute difference, 2*WIDTH bits, unsigned.
  - If ed != 0: err_count += 1; err_sum += ed; err_max = max(err_max, ed); if fail_valid=0, capture fail_in1/fail_in2 and set fail_valid.
  - Advance operands: in2 += 1; when in2 wraps from all-ones to 0, in1 += 1.
  - If the sampled pair was in1=in2=all-ones: go to DONE with operands left at all-ones. Otherwise go to DRIVE with counter=0.
- Accumulator widths never overflow: at most 2^(2W) errors, each ed < 2^(2W). No saturation logic.
- start asserted in DRIVE/SAMPLE is ignored; no restart, no effect on metrics.
- Metrics are updated only in SAMPLE. They are stable and readable throughout DONE and remain stable after a later return to DONE.
- Timing: with N = 2^(2*WIDTH) vectors, done rises on the edge N*(SETTLE_CYCLES+1)+1 edges after (and counting) the edge that samples start.
- Reset mid-sweep: immediate return to IDLE, all results lost; a fresh start begins again at pair (0,0).

Test Plan:
- Exact DUT stub ({overflow,out}=in1*in2), WIDTH=8, SETTLE=1, start pulse -> done after 131073 edges; err_count=0, err_sum=0, err_max=0, fail_valid=0, busy low in DONE.
- DUT stub with product LSB forced to 0, WIDTH=8 -> err_count=16384, err_sum=16384, err_max=1, fail_in1=1, fail_in2=1, fail_valid=1.
- WIDTH=2, SETTLE=3, exact stub -> done after 65 edges. Monitor the operands: in1 steps 0..3 as the outer loop and in2 steps 0..3 as the inner loop. Each pair is held 4 cycles.
- Stub with overflow forced to 0, WIDTH=4 -> err_max=225-(225 mod 16)=224; fail pair (1,... first with product>=16) = in1=2, in2=8; err_count equals the count of pairs with product>=16.
- start re-pulsed mid-sweep -> no restart and the total cycle count is unchanged. rst pulsed mid-sweep -> all outputs 0 asynchronously; a following start gives results identical to a clean run.
- Second start after DONE with the exact stub, following an erroneous run -> metrics cleared on acceptance; final err_count=0.
